// File: rtl/ielfsr_pattern_sequencer_if.sv
// Pattern stream from the sequencer to the CUT driver.
// A pattern moves on every clock edge where valid and ready are both high.
interface ielfsr_pattern_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ielfsr_pattern_sequencer.sv
// Two-phase BIST pattern source around a dual-mode, step-enable LFSR.
// A run seeds the LFSR to all ones. It then streams n0 patterns in mode 0,
// switches to mode 1 without reseeding, and streams n1 more patterns.
// The LFSR advances only when the consumer accepts a pattern.
// "set" is the asynchronous active-low reset of this block; it is not a preset.
module ielfsr_pattern_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 set,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     cfg_n0,
    input  logic [CNT_W-1:0]     cfg_n1,
    input  logic [WIDTH-1:0]     lfsr_q,
    output logic                 lfsr_set_n,
    output logic                 lfsr_mode,
    output logic                 lfsr_step,
    ielfsr_pattern_sequencer_if.master pat,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W:0]       tot_count
);

    typedef enum logic [2:0] {IDLE, SEED, PHASE0, SWITCH, PHASE1, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W:0]   TOT_ONE = 1;

    state_t           state;
    logic [CNT_W-1:0] n0_q;
    logic [CNT_W-1:0] n1_q;
    logic [CNT_W-1:0] cnt;
    logic             valid_q;
    logic             accept;
    logic             last0;
    logic             last1;

    // An abort in the same cycle cancels the handshake, so the LFSR never steps on it.
    assign accept    = valid_q & pat.ready & ~abort;
    assign lfsr_step = accept;
    assign pat.valid = valid_q;
    assign pat.data  = valid_q ? lfsr_q : '0;

    // The phase counters are never compared in a phase whose count is zero,
    // so subtracting one cannot wrap in a state where it matters.
    assign last0 = (cnt == n0_q - CNT_ONE);
    assign last1 = (cnt == n1_q - CNT_ONE);

    // Run sequencing: abort wins over start and accept; all outputs are registered here.
    always_ff @(posedge clk or negedge set) begin
        if (!set) begin
            state      <= IDLE;
            n0_q       <= '0;
            n1_q       <= '0;
            cnt        <= '0;
            valid_q    <= 1'b0;
            lfsr_set_n <= 1'b1;
            lfsr_mode  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tot_count  <= '0;
        end else if (abort) begin
            state      <= IDLE;
            cnt        <= '0;
            valid_q    <= 1'b0;
            lfsr_set_n <= 1'b1;
            lfsr_mode  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SEED;
                        n0_q       <= cfg_n0;
                        n1_q       <= cfg_n1;
                        cnt        <= '0;
                        done       <= 1'b0;
                        tot_count  <= '0;
                        lfsr_mode  <= 1'b0;
                        lfsr_set_n <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SEED: begin
                    lfsr_set_n <= 1'b1;
                    if (n0_q != '0) begin
                        state   <= PHASE0;
                        valid_q <= 1'b1;
                    end else if (n1_q != '0) begin
                        state     <= PHASE1;
                        valid_q   <= 1'b1;
                        lfsr_mode <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                PHASE0: begin
                    if (accept) begin
                        tot_count <= tot_count + TOT_ONE;
                        if (last0) begin
                            state     <= SWITCH;
                            valid_q   <= 1'b0;
                            lfsr_mode <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                SWITCH: begin
                    if (n1_q != '0) begin
                        state   <= PHASE1;
                        valid_q <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                PHASE1: begin
                    if (accept) begin
                        tot_count <= tot_count + TOT_ONE;
                        if (last1) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
